alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Issue/sequencing stage directly upstream of the ALU. Accepts one decoded op per valid/ready handshake,
//  drives ALU enable/op/operands, waits out the multi-cycle shifter's busy window, captures the result
//  and compare flags, resolves the branch condition, and presents {data, rd, taken} to writeback via valid/ready.
// PARAMETERS
//  XLEN        32  operand/result width
//  REGW        5   destination register index width
//  SC_SHIFT    0   1 = ALU built with single-cycle shifter; shifts then follow the non-shift path
// PORTS
//  I_clk          in   1     clock
//  I_reset        in   1     synchronous, active-high reset
//  I_in_valid     in   1     upstream op valid
//  O_in_ready     out  1     op accepted on I_in_valid & O_in_ready
//  I_in_aluop     in   5     ALU opcode (ALUOP_* encoding)
//  I_in_s1        in   XLEN  operand 1
//  I_in_s2        in   XLEN  operand 2
//  I_in_rd        in   REGW  destination register
//  I_in_branch    in   1     op is a conditional branch (aluop must be ALUOP_SUB)
//  I_in_funct3    in   3     branch type: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU
//  O_alu_en       out  1     ALU enable
//  O_alu_op       out  5     ALU opcode
//  O_alu_s1       out  XLEN  ALU operand 1
//  O_alu_s2       out  XLEN  ALU operand 2
//  I_alu_busy     in   1     ALU multi-cycle busy
//  I_alu_data     in   XLEN  ALU registered result
//  I_alu_lt       in   1     ALU registered signed less-than
//  I_alu_ltu      in   1     ALU registered unsigned less-than
//  I_alu_eq       in   1     ALU registered equal
//  O_res_valid    out  1     result valid
//  I_res_ready    in   1     writeback accepts on O_res_valid & I_res_ready
//  O_res_data     out  XLEN  captured ALU result
//  O_res_rd       out  REGW  captured destination register
//  O_res_taken    out  1     branch taken (0 for non-branch)
// BEHAVIOUR
//  Reset: state IDLE, O_res_valid=0, O_res_data=0, O_res_rd=0, O_res_taken=0, op/operand regs=0. The ALU
//   shares I_reset, so reset mid-shift aborts cleanly; the in-flight op is dropped, not replayed.
//  Op/operand/rd/branch/funct3 latched on accept; O_alu_op/s1/s2 driven from these latches, stable until next accept.
//  O_in_ready = (state==IDLE). State machine:
//   IDLE : on accept -> EXEC.
//   EXEC : O_alu_en=1 one cycle. Shift op (SLL/SRL/SRA) and SC_SHIFT==0 -> SHIFT; else -> CAPT.
//   SHIFT: O_alu_en = I_alu_busy (combinational; en must be low in the cycle busy reads 0, else ALU restarts).
//          busy==1 -> stay; busy==0 -> CAPT.
//   CAPT : O_alu_en=0 (ALU holds result/flags). If !O_res_valid | I_res_ready: load output regs, O_res_valid<=1,
//          -> IDLE; else stall in CAPT.
//  Output reg: O_res_valid cleared on I_res_ready when not reloaded same cycle; load and drain in the same cycle
//   keeps valid=1 with new data. Data/rd/taken constant while valid & !ready.
//  Taken = branch & f(funct3): EQ=eq, NE=!eq, LT=lt, GE=!lt, LTU=ltu, GEU=!ltu; funct3 010/011 -> 0.
//  Latency (accept edge = cycle 0): non-shift O_res_valid in cycle 3; shift by n in cycle n+5
//   (EXEC 1, busy high n+1 cycles, busy-low cycle, CAPT). Shift count 0: busy high 1 cycle.
//  Throughput: one op in flight; next accept no earlier than the cycle after CAPT completes.
// STRUCTURE
//  ALUOP_* codes from shared aludefs.vh; add there: `define ALUOP_IS_SHIFT(op) and branch funct3 constants.
//  Sub-module: branch_cond (pure comb, funct3+flags -> taken), reusable by the jump/branch unit.
//  State encoding localparams local to this file.
// TESTING
//  ADD 5+7, rd=3, ready=1 -> valid in cycle 3, data=12, rd=3, taken=0; O_alu_en high exactly 1 cycle.
//  SLL 1 by 31 -> en never high in a busy-low cycle after EXEC; data=0x80000000 in cycle 36; SRA 0x80000000
//   by 4 -> 0xF8000000; SLL by 0 -> data=s1, valid in cycle 5.
//  BLT s1=0xFFFFFFFF s2=1 -> taken=1; BLTU same operands -> taken=0; BEQ 9,9 -> taken=1; BNE 9,9 -> 0.
//  Backpressure: ready=0 for 10 cycles after op1; op2 accepted -> op2 stalls in CAPT, op1 data unchanged
//   throughout; ready=1 -> op1 drains, op2 loaded next cycle, no loss or duplication.
//  Reset asserted mid-SLL (busy=1) -> next cycle IDLE, in_ready=1, res_valid=0; following ADD 1+1 -> 2.
//  Random op stream vs. reference model with random in_valid/res_ready: result order, data, rd, taken match.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU opcode and branch-condition encodings used by the issue stage and its neighbours.
package alu_issue_ctrl_pkg;

   localparam int ALUOP_W = 5;

   localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 5'd0;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 5'd1;
   localparam logic [ALUOP_W-1:0] ALUOP_SLL  = 5'd2;
   localparam logic [ALUOP_W-1:0] ALUOP_SLT  = 5'd3;
   localparam logic [ALUOP_W-1:0] ALUOP_SLTU = 5'd4;
   localparam logic [ALUOP_W-1:0] ALUOP_XOR  = 5'd5;
   localparam logic [ALUOP_W-1:0] ALUOP_SRL  = 5'd6;
   localparam logic [ALUOP_W-1:0] ALUOP_SRA  = 5'd7;
   localparam logic [ALUOP_W-1:0] ALUOP_OR   = 5'd8;
   localparam logic [ALUOP_W-1:0] ALUOP_AND  = 5'd9;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   function automatic logic aluop_is_shift(input logic [ALUOP_W-1:0] op);
      return (op == ALUOP_SLL) || (op == ALUOP_SRL) || (op == ALUOP_SRA);
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_branch_cond.sv
// Branch condition resolve from funct3 and ALU compare flags; pure combinational.
module branch_cond
   import alu_issue_ctrl_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic       i_eq,
   input  logic       i_lt,
   input  logic       i_ltu,
   output logic       o_taken
);

   always_comb begin
      o_taken = 1'b0;
      case (i_funct3)
         F3_BEQ:  o_taken = i_eq;
         F3_BNE:  o_taken = !i_eq;
         F3_BLT:  o_taken = i_lt;
         F3_BGE:  o_taken = !i_lt;
         F3_BLTU: o_taken = i_ltu;
         F3_BGEU: o_taken = !i_ltu;
         default: o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue/sequencing stage: accepts one op, runs the ALU (incl. multi-cycle shifts),
// captures result and branch outcome, and hands it to writeback over valid/ready.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int REGW     = 5,
   parameter bit SC_SHIFT = 1'b0
) (
   input  logic               I_clk,
   input  logic               I_reset,
   input  logic               I_in_valid,
   output logic               O_in_ready,
   input  logic [ALUOP_W-1:0] I_in_aluop,
   input  logic [XLEN-1:0]    I_in_s1,
   input  logic [XLEN-1:0]    I_in_s2,
   input  logic [REGW-1:0]    I_in_rd,
   input  logic               I_in_branch,
   input  logic [2:0]         I_in_funct3,
   output logic               O_alu_en,
   output logic [ALUOP_W-1:0] O_alu_op,
   output logic [XLEN-1:0]    O_alu_s1,
   output logic [XLEN-1:0]    O_alu_s2,
   input  logic               I_alu_busy,
   input  logic [XLEN-1:0]    I_alu_data,
   input  logic               I_alu_lt,
   input  logic               I_alu_ltu,
   input  logic               I_alu_eq,
   output logic               O_res_valid,
   input  logic               I_res_ready,
   output logic [XLEN-1:0]    O_res_data,
   output logic [REGW-1:0]    O_res_rd,
   output logic               O_res_taken
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_CAPT  = 2'd3
   } state_t;

   state_t              r_state;
   logic [ALUOP_W-1:0]  r_op;
   logic [XLEN-1:0]     r_s1;
   logic [XLEN-1:0]     r_s2;
   logic [REGW-1:0]     r_rd;
   logic                r_branch;
   logic [2:0]          r_funct3;

   logic w_accept;
   logic w_load;
   logic w_cond;

   assign O_in_ready = (r_state == ST_IDLE);
   assign w_accept   = I_in_valid && O_in_ready;
   assign w_load     = (r_state == ST_CAPT) && (!O_res_valid || I_res_ready);

   assign O_alu_op = r_op;
   assign O_alu_s1 = r_s1;
   assign O_alu_s2 = r_s2;

   // While shifting, en tracks busy so it is already low in the busy-low cycle;
   // a high en there would be seen by the ALU as a fresh start.
   always_comb begin
      O_alu_en = 1'b0;
      case (r_state)
         ST_EXEC:  O_alu_en = 1'b1;
         ST_SHIFT: O_alu_en = I_alu_busy;
         default:  O_alu_en = 1'b0;
      endcase
   end

   branch_cond u_branch_cond (
      .i_funct3 (r_funct3),
      .i_eq     (I_alu_eq),
      .i_lt     (I_alu_lt),
      .i_ltu    (I_alu_ltu),
      .o_taken  (w_cond)
   );

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         r_state  <= ST_IDLE;
         r_op     <= '0;
         r_s1     <= '0;
         r_s2     <= '0;
         r_rd     <= '0;
         r_branch <= 1'b0;
         r_funct3 <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_accept) begin
               r_op     <= I_in_aluop;
               r_s1     <= I_in_s1;
               r_s2     <= I_in_s2;
               r_rd     <= I_in_rd;
               r_branch <= I_in_branch;
               r_funct3 <= I_in_funct3;
               r_state  <= ST_EXEC;
            end
            ST_EXEC:  r_state <= (aluop_is_shift(r_op) && !SC_SHIFT) ? ST_SHIFT : ST_CAPT;
            ST_SHIFT: if (!I_alu_busy) r_state <= ST_CAPT;
            ST_CAPT:  if (w_load) r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   // Output register: a load wins over a drain in the same cycle, keeping valid high.
   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         O_res_valid <= 1'b0;
         O_res_data  <= '0;
         O_res_rd    <= '0;
         O_res_taken <= 1'b0;
      end else if (w_load) begin
         O_res_valid <= 1'b1;
         O_res_data  <= I_alu_data;
         O_res_rd    <= r_rd;
         O_res_taken <= r_branch && w_cond;
      end else if (I_res_ready) begin
         O_res_valid <= 1'b0;
      end
   end

endmodule
